// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the dual-wide instruction fetch unit.
package inst_fetch_pkg;
   localparam int PC_BUS    = 32;
   localparam int INST_BUS  = 32;
   localparam int FETCH_BUS = 64;

   typedef enum logic [1:0] {
      IF_REQ     = 2'd0,
      IF_WAIT    = 2'd1,
      IF_PRESENT = 2'd2
   } if_state_t;

   // Slot1 is the MSB of issue; 2'b10 is reserved and never produced.
   localparam logic [1:0] ISSUE_NONE  = 2'b00;
   localparam logic [1:0] ISSUE_SLOT1 = 2'b10;
   localparam logic [1:0] ISSUE_SLOT2 = 2'b01;
   localparam logic [1:0] ISSUE_BOTH  = 2'b11;

   function automatic logic [PC_BUS-1:0] align8(input logic [PC_BUS-1:0] pc);
      return {pc[PC_BUS-1:3], 3'b000};
   endfunction
endpackage

// File: rtl/inst_fetch_pack.sv
// Splits one 64-bit fetch response into the two issue slots based on
// which word of the doubleword the request PC points at.
module inst_fetch_pack
   import inst_fetch_pkg::*;
(
   input  logic [PC_BUS-1:0]    req_pc,
   input  logic [FETCH_BUS-1:0] rdata,
   output logic [1:0]           issue,
   output logic [INST_BUS-1:0]  in1_inst,
   output logic [PC_BUS-1:0]    in1_pc,
   output logic [PC_BUS-1:0]    in1_npc,
   output logic [INST_BUS-1:0]  in2_inst,
   output logic [PC_BUS-1:0]    in2_pc,
   output logic [PC_BUS-1:0]    in2_npc
);

   always_comb begin
      issue    = ISSUE_NONE;
      in1_inst = '0;
      in1_pc   = '0;
      in1_npc  = '0;
      in2_inst = '0;
      in2_pc   = '0;
      in2_npc  = '0;
      if (!req_pc[2]) begin
         issue    = ISSUE_BOTH;
         in1_inst = rdata[31:0];
         in1_pc   = req_pc;
         in1_npc  = req_pc + 32'd4;
         in2_inst = rdata[63:32];
         in2_pc   = req_pc + 32'd4;
         in2_npc  = req_pc + 32'd8;
      end else begin
         // Entry in the upper word: only the high half is useful.
         issue    = ISSUE_SLOT2;
         in2_inst = rdata[63:32];
         in2_pc   = req_pc;
         in2_npc  = req_pc + 32'd4;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Dual-wide fetch unit: one aligned 64-bit fetch in flight, response
// presented to the instruction buffer with a valid/ready handshake.
//
// state      | meaning
// IF_REQ     | request driven to imem at fetch_pc, waiting for accept
// IF_WAIT    | request accepted, waiting for rvalid (dropped if kill)
// IF_PRESENT | slots valid on issue/in1/in2 until instbuf_full is low
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 branch_flag,
   input  logic [PC_BUS-1:0]    branch_target,
   input  logic                 instbuf_full,
   output logic                 imem_req,
   output logic [PC_BUS-1:0]    imem_addr,
   input  logic                 imem_ready,
   input  logic                 imem_rvalid,
   input  logic [FETCH_BUS-1:0] imem_rdata,
   output logic [1:0]           issue,
   output logic [INST_BUS-1:0]  in1_inst,
   output logic [PC_BUS-1:0]    in1_pc,
   output logic [PC_BUS-1:0]    in1_npc,
   output logic [INST_BUS-1:0]  in2_inst,
   output logic [PC_BUS-1:0]    in2_pc,
   output logic [PC_BUS-1:0]    in2_npc,
   output logic                 stop
);

   if_state_t         state, state_nxt;
   logic [PC_BUS-1:0] fetch_pc, fetch_pc_nxt;
   logic [PC_BUS-1:0] req_pc, req_pc_nxt;
   logic              kill, kill_nxt;
   logic [1:0]        issue_nxt;
   logic              load;

   logic [1:0]          pk_issue;
   logic [INST_BUS-1:0] pk_in1_inst, pk_in2_inst;
   logic [PC_BUS-1:0]   pk_in1_pc, pk_in1_npc, pk_in2_pc, pk_in2_npc;

   inst_fetch_pack u_pack (
      .req_pc   (req_pc),
      .rdata    (imem_rdata),
      .issue    (pk_issue),
      .in1_inst (pk_in1_inst),
      .in1_pc   (pk_in1_pc),
      .in1_npc  (pk_in1_npc),
      .in2_inst (pk_in2_inst),
      .in2_pc   (pk_in2_pc),
      .in2_npc  (pk_in2_npc)
   );

   assign imem_req  = (state == IF_REQ);
   assign imem_addr = align8(fetch_pc);
   assign stop      = (issue != ISSUE_NONE) && instbuf_full;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_pc_nxt   = req_pc;
      kill_nxt     = kill;
      issue_nxt    = issue;
      load         = 1'b0;
      if (branch_flag) begin
         fetch_pc_nxt = branch_target & ~32'h3;
         issue_nxt    = ISSUE_NONE;
         if (state == IF_WAIT && imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = IF_REQ;
         end else if (state == IF_WAIT || (state == IF_REQ && imem_ready)) begin
            // A response is (or will be) outstanding; swallow it.
            kill_nxt  = 1'b1;
            state_nxt = IF_WAIT;
         end else begin
            state_nxt = IF_REQ;
         end
      end else begin
         unique case (state)
            IF_REQ: begin
               if (imem_ready) begin
                  req_pc_nxt = fetch_pc;
                  state_nxt  = IF_WAIT;
               end
            end
            IF_WAIT: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     kill_nxt  = 1'b0;
                     state_nxt = IF_REQ;
                  end else begin
                     load         = 1'b1;
                     issue_nxt    = pk_issue;
                     fetch_pc_nxt = align8(req_pc) + 32'd8;
                     state_nxt    = IF_PRESENT;
                  end
               end
            end
            IF_PRESENT: begin
               if (!instbuf_full) begin
                  issue_nxt = ISSUE_NONE;
                  state_nxt = IF_REQ;
               end
            end
            default: state_nxt = IF_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IF_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         kill     <= 1'b0;
         issue    <= ISSUE_NONE;
         in1_inst <= '0;
         in1_pc   <= '0;
         in1_npc  <= '0;
         in2_inst <= '0;
         in2_pc   <= '0;
         in2_npc  <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         req_pc   <= req_pc_nxt;
         kill     <= kill_nxt;
         issue    <= issue_nxt;
         if (load) begin
            in1_inst <= pk_in1_inst;
            in1_pc   <= pk_in1_pc;
            in1_npc  <= pk_in1_npc;
            in2_inst <= pk_in2_inst;
            in2_pc   <= pk_in2_pc;
            in2_npc  <= pk_in2_npc;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small latency-programmable memory
// responder; memory word at address a holds 32'hA + a/4.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = '0;
   logic        instbuf_full = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [63:0] imem_rdata = '0;
   logic [1:0]  issue;
   logic [31:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
   logic        stop;

   int vectors = 0;
   int errs = 0;
   int lat = 1;
   int pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .instbuf_full  (instbuf_full),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .issue         (issue),
      .in1_inst      (in1_inst),
      .in1_pc        (in1_pc),
      .in1_npc       (in1_npc),
      .in2_inst      (in2_inst),
      .in2_pc        (in2_pc),
      .in2_npc       (in2_npc),
      .stop          (stop)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'hA + (a >> 2);
   endfunction

   // Responder: decides what the DUT will see at the next rising edge.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         pend_cnt    = 0;
         imem_rvalid = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = {word_at(pend_addr + 32'd4), word_at(pend_addr)};
            end
         end
         if (imem_req && imem_ready) begin
            pend_addr = imem_addr;
            pend_cnt  = lat;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset, zero-wait memory.
      @(negedge clk);
      @(negedge clk);
      chk("rst_issue", {30'd0, issue}, 32'h0);
      chk("rst_stop", {31'd0, stop}, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'h1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_in1_pc", in1_pc, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("f0_req_wait", {31'd0, imem_req}, 32'h0);
      @(negedge clk);
      chk("f0_issue", {30'd0, issue}, 32'h3);
      chk("f0_in1_pc", in1_pc, 32'h0);
      chk("f0_in1_npc", in1_npc, 32'h4);
      chk("f0_in1_inst", in1_inst, 32'hA);
      chk("f0_in2_pc", in2_pc, 32'h4);
      chk("f0_in2_npc", in2_npc, 32'h8);
      chk("f0_in2_inst", in2_inst, 32'hB);
      chk("f0_stop", {31'd0, stop}, 32'h0);
      @(negedge clk);
      chk("f0_done", {30'd0, issue}, 32'h0);
      chk("f1_req", {31'd0, imem_req}, 32'h1);
      chk("f1_addr", imem_addr, 32'h8);

      // Redirect in REQ to an odd-word target; the accepted fetch at 8 is killed.
      branch_flag = 1'b1;
      branch_target = 32'h0000_0107;
      @(negedge clk);
      branch_flag = 1'b0;
      chk("br_req_wait", {31'd0, imem_req}, 32'h0);
      @(negedge clk);
      chk("br_killed", {30'd0, issue}, 32'h0);
      chk("br_req", {31'd0, imem_req}, 32'h1);
      chk("br_addr", imem_addr, 32'h100);
      @(negedge clk);
      @(negedge clk);
      chk("odd_issue", {30'd0, issue}, 32'h1);
      chk("odd_in2_pc", in2_pc, 32'h104);
      chk("odd_in2_npc", in2_npc, 32'h108);
      chk("odd_in2_inst", in2_inst, 32'h4B);
      chk("odd_in1_pc", in1_pc, 32'h0);
      chk("odd_in1_inst", in1_inst, 32'h0);

      // Back-pressure for five edges while presenting.
      instbuf_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_issue", {30'd0, issue}, 32'h1);
         chk("bp_stop", {31'd0, stop}, 32'h1);
         chk("bp_req", {31'd0, imem_req}, 32'h0);
         chk("bp_in2_inst", in2_inst, 32'h4B);
      end
      instbuf_full = 1'b0;
      @(negedge clk);
      chk("bp_release_issue", {30'd0, issue}, 32'h0);
      chk("bp_release_stop", {31'd0, stop}, 32'h0);
      chk("bp_next_addr", imem_addr, 32'h108);
      chk("bp_next_req", {31'd0, imem_req}, 32'h1);

      // Redirect while waiting on a 3-cycle memory.
      lat = 3;
      @(negedge clk);
      chk("w_req", {31'd0, imem_req}, 32'h0);
      branch_flag = 1'b1;
      branch_target = 32'h0000_0200;
      @(negedge clk);
      branch_flag = 1'b0;
      @(negedge clk);
      chk("w_issue0", {30'd0, issue}, 32'h0);
      chk("w_req0", {31'd0, imem_req}, 32'h0);
      @(negedge clk);
      chk("w_dropped", {30'd0, issue}, 32'h0);
      chk("w_req", {31'd0, imem_req}, 32'h1);
      chk("w_addr", imem_addr, 32'h200);

      // Redirect in the same cycle as rvalid.
      lat = 1;
      @(negedge clk);
      chk("rv_req", {31'd0, imem_req}, 32'h0);
      branch_flag = 1'b1;
      branch_target = 32'h0000_0300;
      @(negedge clk);
      branch_flag = 1'b0;
      chk("rv_issue", {30'd0, issue}, 32'h0);
      chk("rv_req", {31'd0, imem_req}, 32'h1);
      chk("rv_addr", imem_addr, 32'h300);
      @(negedge clk);
      @(negedge clk);
      chk("rv_next_issue", {30'd0, issue}, 32'h3);
      chk("rv_in1_pc", in1_pc, 32'h300);
      chk("rv_in1_inst", in1_inst, 32'hCA);
      chk("rv_in2_npc", in2_npc, 32'h308);
      chk("rv_in2_inst", in2_inst, 32'hCB);

      // Reset while presenting both slots with the buffer full.
      instbuf_full = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("mr_issue", {30'd0, issue}, 32'h0);
      chk("mr_stop", {31'd0, stop}, 32'h0);
      chk("mr_req", {31'd0, imem_req}, 32'h1);
      chk("mr_addr", imem_addr, 32'h0);
      chk("mr_in1_pc", in1_pc, 32'h0);
      rst = 1'b0;
      instbuf_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_refetch_issue", {30'd0, issue}, 32'h3);
      chk("mr_refetch_inst", in1_inst, 32'hA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Dual-wide instruction fetch unit; the producer side of the IF→instruction-buffer interface.
- Issues one 64-bit aligned fetch at a time to instruction memory.
- Splits each response into up to two slots (pc/npc/inst) and presents them on the issue/in1/in2 interface with a valid/ready handshake. `issue` nonzero is valid; `!instbuf_full` is ready.
- Handles branch redirect (fetch_pc reload plus kill of any in-flight response) and downstream back-pressure.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; one clock
branch_flag  in  1  redirect request from execute; highest priority after rst
branch_target  in  32  redirect PC; bits [1:0] ignored (treated as 0)
instbuf_full  in  1  buffer not ready; a transfer occurs at a clk edge where issue!=0 && !instbuf_full
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, always {fetch_pc[31:3],3'b000}
imem_ready  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (exactly one per accepted request, ≥1 cycle later)
imem_rdata  in  64  [31:0] = word at addr, [63:32] = word at addr+4
issue  out  2  00 none, 10 slot1 only, 01 slot2 only, 11 both
in1_inst/in1_pc/in1_npc  out  32 each  slot1 payload
in2_inst/in2_pc/in2_npc  out  32 each  slot2 payload
stop  out  1  fetch stalled by downstream: issue!=0 && instbuf_full

Behaviour:
- All outputs are registered except `stop`, `imem_req` and `imem_addr`, which are decoded from state/fetch_pc.
- Reset values: state=REQ; fetch_pc=RESET_PC; kill=0; issue=00; all in1/in2 fields=0; so imem_req=1 and stop=0 in the first cycle after reset.

FSM states:
- REQ: imem_req=1. On imem_ready → WAIT and latch req_pc=fetch_pc.
- WAIT: imem_req=0. On imem_rvalid:
  - if kill=1: drop the data, clear kill → REQ;
  - else: load the slot registers, set issue, set fetch_pc={req_pc[31:3],3'b000}+8 → PRESENT.
- PRESENT: hold issue and payload unchanged. At the first edge with instbuf_full=0: issue←00 → REQ. No new request while in PRESENT.

Packing from req_pc:
- req_pc[2]=0 → issue=11.
  - in1 = {pc=req_pc, npc=req_pc+4, inst=rdata[31:0]}.
  - in2 = {pc=req_pc+4, npc=req_pc+8, inst=rdata[63:32]}.
- req_pc[2]=1 → issue=01.
  - in2 = {pc=req_pc, npc=req_pc+4, inst=rdata[63:32]}.
  - in1 = all zeros.
- Encoding 10 is reserved and never generated.
- npc is sequential (no prediction). PC arithmetic is modulo 2^32.
- npc=0 only at the 0xFFFF_FFFC wrap. That case is unsupported, because the buffer treats an all-zero entry as empty.

branch_flag (no rst), any state, same edge:
- fetch_pc←branch_target&~3; issue←00; payload unchanged (don't care).
- In WAIT, or in REQ with imem_ready=1: kill←1, state→WAIT. The outstanding response is discarded.
- In WAIT with imem_rvalid=1 in the same cycle: that response is dropped, kill←0, state→REQ.
- Otherwise: state→REQ.
- A transfer coinciding with branch_flag is still taken by the buffer, which flushes it; inst_fetch treats it as done.

Further rules:
- rst mid-transaction: state→REQ and kill←0. The memory guarantees no stale rvalid after rst.
- branch_flag held for several cycles: fetch_pc reloads every cycle; no request completes until it is released.
- Throughput: at most one fetch per 3 cycles with zero-wait memory.

Decomposition:
- def.vh additions:
  - `ISSUE_NONE/`ISSUE_SLOT1/`ISSUE_SLOT2/`ISSUE_BOTH encodings;
  - FSM state codes `IF_REQ/`IF_WAIT/`IF_PRESENT;
  - `FETCH_BUS (64);
  - reuse `PC_BUS and `INST_BUS.
- One combinational sub-module, fetch_pack: (req_pc, rdata) → issue plus both slot payloads.
- FSM, fetch_pc and kill stay in inst_fetch.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory, rdata={32'hB,32'hA}, full=0 → imem_addr=0; issue=11; in1={0,4,A}; in2={4,8,B}; next imem_addr=8.
- branch_target=0x104 → imem_addr=0x100; issue=01; in2={0x104,0x108,rdata[63:32]}; in1=0; next imem_addr=0x108.
- instbuf_full=1 for 5 cycles while in PRESENT → issue and payload stable; stop=1 for 5 cycles; no imem_req; after full drops, exactly one transfer, then issue=00.
- branch_flag (target 0x200) while in WAIT with 3-cycle memory latency → the old response is discarded (issue stays 00); the next request has imem_addr=0x200.
- branch_flag in the same cycle as imem_rvalid → no issue from that data; imem_req=1 to the branch target next cycle.
- rst asserted while in PRESENT with issue=11 → issue=00, stop=0, imem_req=1, imem_addr=RESET_PC next cycle.
